// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and fixed-window access sequencer for a 256Kx16 asynchronous SRAM.
// Every SRAM strobe and the data-pin enable come straight from flops.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [17:0] addr0,
   input  logic [17:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   input  logic [1:0]  be0,
   input  logic [1:0]  be1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata,
   output logic [17:0] ram_adr,
   output logic [15:0] ram_dat_o,
   output logic        ram_dat_oe,
   input  logic [15:0] ram_dat_i,
   output logic        ram_cs,
   output logic        ram_oe,
   output logic        ram_we,
   output logic        ram_lb,
   output logic        ram_ub
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_TURN   = 2'd2;
   localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [1:0]  be_q, be_d;
   logic [17:0] adr_q, adr_d;
   logic [15:0] dat_o_q, dat_o_d;
   logic        dat_oe_q, dat_oe_d;
   logic [15:0] rdata_q, rdata_d;
   logic        cs_q, cs_d, oe_q, oe_d, wen_q, wen_d, lb_q, lb_d, ub_q, ub_d;
   logic [1:0]  gnt_q, gnt_d, rvalid_q, rvalid_d;

   logic        sel;
   logic        sel_we;
   logic [17:0] sel_adr;
   logic [15:0] sel_wdata;
   logic [1:0]  sel_be;

   // On a tie the port that did not win last time is served.
   always_comb begin
      sel       = (req0 && req1) ? ~last_q : req1;
      sel_we    = sel ? we1    : we0;
      sel_adr   = sel ? addr1  : addr0;
      sel_wdata = sel ? wdata1 : wdata0;
      sel_be    = sel ? be1    : be0;
   end

   // NOTE: every _d gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      port_d   = port_q;
      we_d     = we_q;
      be_d     = be_q;
      adr_d    = adr_q;
      dat_o_d  = dat_o_q;
      dat_oe_d = dat_oe_q;
      rdata_d  = rdata_q;
      cs_d     = 1'b1;
      oe_d     = 1'b1;
      wen_d    = 1'b1;
      lb_d     = 1'b1;
      ub_d     = 1'b1;
      gnt_d    = 2'b00;
      rvalid_d = 2'b00;
      case (state_q)
         ST_IDLE: begin
            dat_oe_d = 1'b0;
            if (req0 || req1) begin
               state_d  = ST_ACCESS;
               cnt_d    = CNT_LOAD;
               last_d   = sel;
               port_d   = sel;
               we_d     = sel_we;
               be_d     = sel_be;
               adr_d    = sel_adr;
               if (sel_we) dat_o_d = sel_wdata;
               dat_oe_d = sel_we;
               cs_d     = 1'b0;
               oe_d     = sel_we;
               wen_d    = ~sel_we;
               lb_d     = ~sel_be[0];
               ub_d     = ~sel_be[1];
               gnt_d    = sel ? 2'b10 : 2'b01;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Address and write data stay on the pins through TURN for hold time.
               state_d = ST_TURN;
               if (!we_q) begin
                  rdata_d  = {be_q[1] ? ram_dat_i[15:8] : 8'h00,
                              be_q[0] ? ram_dat_i[7:0]  : 8'h00};
                  rvalid_d = port_q ? 2'b10 : 2'b01;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
               cs_d  = 1'b0;
               oe_d  = we_q;
               wen_d = ~we_q;
               lb_d  = ~be_q[0];
               ub_d  = ~be_q[1];
            end
         end
         ST_TURN: begin
            state_d  = ST_IDLE;
            dat_oe_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         last_q   <= 1'b1;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 2'b00;
         adr_q    <= 18'd0;
         dat_o_q  <= 16'd0;
         dat_oe_q <= 1'b0;
         rdata_q  <= 16'd0;
         cs_q     <= 1'b1;
         oe_q     <= 1'b1;
         wen_q    <= 1'b1;
         lb_q     <= 1'b1;
         ub_q     <= 1'b1;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         port_q   <= port_d;
         we_q     <= we_d;
         be_q     <= be_d;
         adr_q    <= adr_d;
         dat_o_q  <= dat_o_d;
         dat_oe_q <= dat_oe_d;
         rdata_q  <= rdata_d;
         cs_q     <= cs_d;
         oe_q     <= oe_d;
         wen_q    <= wen_d;
         lb_q     <= lb_d;
         ub_q     <= ub_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gnt0       = gnt_q[0];
   assign gnt1       = gnt_q[1];
   assign rvalid0    = rvalid_q[0];
   assign rvalid1    = rvalid_q[1];
   assign rdata      = rdata_q;
   assign ram_adr    = adr_q;
   assign ram_dat_o  = dat_o_q;
   assign ram_dat_oe = dat_oe_q;
   assign ram_cs     = cs_q;
   assign ram_oe     = oe_q;
   assign ram_we     = wen_q;
   assign ram_lb     = lb_q;
   assign ram_ub     = ub_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (W = 2, 1, 15), each with an SRAM pin model,
// a transaction-timeline reference model and a per-cycle compare, plus directed scenarios.
module tb_sram_arbiter;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst        [N];
   logic        req0       [N];
   logic        req1       [N];
   logic        we0        [N];
   logic        we1        [N];
   logic [17:0] addr0      [N];
   logic [17:0] addr1      [N];
   logic [15:0] wdata0     [N];
   logic [15:0] wdata1     [N];
   logic [1:0]  be0        [N];
   logic [1:0]  be1        [N];
   logic        gnt0       [N];
   logic        gnt1       [N];
   logic        rvalid0    [N];
   logic        rvalid1    [N];
   logic [15:0] rdata      [N];
   logic [17:0] ram_adr    [N];
   logic [15:0] ram_dat_o  [N];
   logic        ram_dat_oe [N];
   logic [15:0] ram_dat_i  [N];
   logic        ram_cs     [N];
   logic        ram_oe     [N];
   logic        ram_we     [N];
   logic        ram_lb     [N];
   logic        ram_ub     [N];

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [9:0] PINS_IDLE = 10'b0000_11111_0;

   typedef struct {
      int          gnt_at;
      int          rv_at;
      int          cs_low;
      int          we_low;
      int          lb_low;
      int          ub_low;
      logic [15:0] rd;
      logic        doe_turn;
      logic        doe_idle;
   } acc_t;

   always #5 clk = ~clk;

   function automatic int w_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 15;
   endfunction

   function automatic logic [15:0] init_word(input int a);
      logic [7:0] b;
      b = 8'(a);
      return {b ^ 8'hC3, b ^ 8'h3C};
   endfunction

   // {gnt0, gnt1, rvalid0, rvalid1, cs, oe, we, lb, ub, dat_oe}
   function automatic logic [9:0] pins(input int i);
      return {gnt0[i], gnt1[i], rvalid0[i], rvalid1[i], ram_cs[i], ram_oe[i],
              ram_we[i], ram_lb[i], ram_ub[i], ram_dat_oe[i]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;

      sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req0      (req0[g]),
         .req1      (req1[g]),
         .we0       (we0[g]),
         .we1       (we1[g]),
         .addr0     (addr0[g]),
         .addr1     (addr1[g]),
         .wdata0    (wdata0[g]),
         .wdata1    (wdata1[g]),
         .be0       (be0[g]),
         .be1       (be1[g]),
         .gnt0      (gnt0[g]),
         .gnt1      (gnt1[g]),
         .rvalid0   (rvalid0[g]),
         .rvalid1   (rvalid1[g]),
         .rdata     (rdata[g]),
         .ram_adr   (ram_adr[g]),
         .ram_dat_o (ram_dat_o[g]),
         .ram_dat_oe(ram_dat_oe[g]),
         .ram_dat_i (ram_dat_i[g]),
         .ram_cs    (ram_cs[g]),
         .ram_oe    (ram_oe[g]),
         .ram_we    (ram_we[g]),
         .ram_lb    (ram_lb[g]),
         .ram_ub    (ram_ub[g])
      );

      // SRAM pin model and the reference model's own memory image, both from the same seed.
      logic [15:0] sram    [256];
      logic [15:0] exp_mem [256];
      initial begin
         for (int a = 0; a < 256; a++) begin
            sram[a]    = init_word(a);
            exp_mem[a] = init_word(a);
         end
      end

      assign ram_dat_i[g] = (!ram_cs[g] && !ram_oe[g]) ? sram[ram_adr[g][7:0]] : 16'hDEAD;

      always @(negedge clk) begin
         if (!ram_cs[g] && !ram_we[g]) begin
            if (!ram_lb[g]) sram[ram_adr[g][7:0]][7:0]  = ram_dat_o[g][7:0];
            if (!ram_ub[g]) sram[ram_adr[g][7:0]][15:8] = ram_dat_o[g][15:8];
         end
      end

      // Reference model: records the edge at which a request is accepted; the pins in any
      // later cycle follow from the distance to that edge.
      int          ecount = 0;
      int          start  = 0;
      bit          act    = 1'b0;
      bit          m_we   = 1'b0;
      bit          m_port = 1'b0;
      bit          m_last = 1'b1;
      logic [17:0] m_adr  = '0;
      logic [15:0] m_wd   = '0;
      logic [15:0] m_rd   = '0;
      logic [1:0]  m_be   = '0;

      always @(posedge clk or posedge rst[g]) begin
         if (rst[g]) begin
            act    = 1'b0;
            m_last = 1'b1;
            m_adr  = '0;
         end else begin
            ecount++;
            if ((!act || ecount - start >= W + 2) && (req0[g] || req1[g])) begin
               m_port = (req0[g] && req1[g]) ? !m_last : req1[g];
               m_last = m_port;
               act    = 1'b1;
               start  = ecount;
               m_we   = m_port ? we1[g]    : we0[g];
               m_adr  = m_port ? addr1[g]  : addr0[g];
               m_wd   = m_port ? wdata1[g] : wdata0[g];
               m_be   = m_port ? be1[g]    : be0[g];
               if (m_we) begin
                  if (m_be[0]) exp_mem[m_adr[7:0]][7:0]  = m_wd[7:0];
                  if (m_be[1]) exp_mem[m_adr[7:0]][15:8] = m_wd[15:8];
               end else begin
                  m_rd = {m_be[1] ? exp_mem[m_adr[7:0]][15:8] : 8'h00,
                          m_be[0] ? exp_mem[m_adr[7:0]][7:0]  : 8'h00};
               end
            end
         end
      end

      logic [15:0] rd_hold = '0;

      always @(negedge clk) begin
         if (rst[g]) begin
            rd_hold = '0;
         end else begin
            int         k;
            logic [9:0] e;
            k = (act && ecount - start <= W) ? ecount - start + 1 : 0;
            if (k >= 1 && k <= W)
               e = {k == 1 && !m_port, k == 1 && m_port, 2'b00, 1'b0, m_we, !m_we,
                    !m_be[0], !m_be[1], m_we};
            else if (k == W + 1)
               e = {2'b00, !m_we && !m_port, !m_we && m_port, 5'b11111, m_we};
            else
               e = PINS_IDLE;
            check($sformatf("pins[%0d]", g), 32'(pins(g)), 32'(e));
            check($sformatf("adr[%0d]", g), 32'(ram_adr[g]), 32'(m_adr));
            if (k != 0 && m_we) check($sformatf("dat_o[%0d]", g), 32'(ram_dat_o[g]), 32'(m_wd));
            if (k == W + 1 && !m_we) rd_hold = m_rd;
            check($sformatf("rdata[%0d]", g), 32'(rdata[g]), 32'(rd_hold));
            check($sformatf("oe_we_excl[%0d]", g), 32'(ram_oe[g] | ram_we[g]), 32'd1);
         end
      end
   end

   task automatic drive(input int i, input int p, input logic r, input logic w,
                        input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
      if (p == 0) begin
         req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d; be0[i] = b;
      end else begin
         req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d; be1[i] = b;
      end
   endtask

   task automatic drop(input int i, input int p);
      if (p == 0) req0[i] = 1'b0;
      else        req1[i] = 1'b0;
   endtask

   // One access from an idle arbiter; observes W+2 cycles and ends in the IDLE cycle.
   task automatic access(input int i, input int p, input logic w, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] b, output acc_t r);
      int wc;
      wc = w_of(i);
      r  = '{default: 0};
      drive(i, p, 1'b1, w, a, d, b);
      for (int n = 1; n <= wc + 2; n++) begin
         @(negedge clk);
         if ((p == 0 ? gnt0[i] : gnt1[i]) && r.gnt_at == 0) begin
            r.gnt_at = n;
            drop(i, p);
         end
         if ((p == 0 ? rvalid0[i] : rvalid1[i]) && r.rv_at == 0) begin
            r.rv_at = n;
            r.rd    = rdata[i];
         end
         if (!ram_cs[i]) r.cs_low++;
         if (!ram_we[i]) r.we_low++;
         if (!ram_lb[i]) r.lb_low++;
         if (!ram_ub[i]) r.ub_low++;
         if (n == wc + 1) r.doe_turn = ram_dat_oe[i];
         if (n == wc + 2) r.doe_idle = ram_dat_oe[i];
      end
      drop(i, p);
   endtask

   // Both ports request continuously until `count` grants; checks order and spacing.
   task automatic contend(input int i, input int count, input int spacing);
      int ports[$];
      int at[$];
      int n;
      n = 0;
      drive(i, 0, 1'b1, 1'b0, 18'h00030, 16'h0000, 2'b11);
      drive(i, 1, 1'b1, 1'b0, 18'h00031, 16'h0000, 2'b11);
      while (ports.size() < count && n < count * spacing + 20) begin
         @(negedge clk);
         n++;
         if (gnt0[i]) begin ports.push_back(0); at.push_back(n); end
         if (gnt1[i]) begin ports.push_back(1); at.push_back(n); end
      end
      drop(i, 0);
      drop(i, 1);
      check($sformatf("grant_count[%0d]", i), ports.size(), count);
      for (int j = 0; j < ports.size(); j++) begin
         check($sformatf("grant_order[%0d].%0d", i, j), ports[j], j % 2);
         if (j > 0) check($sformatf("grant_spacing[%0d].%0d", i, j), at[j] - at[j-1], spacing);
      end
      repeat (w_of(i) + 1) @(negedge clk);
   endtask

   initial begin
      acc_t r;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1;
         drive(i, 0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
         drive(i, 1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b00);
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("reset_pins[%0d]", i), 32'(pins(i)), 32'(PINS_IDLE));
         check($sformatf("reset_adr[%0d]", i), 32'(ram_adr[i]), 32'd0);
         check($sformatf("reset_dat_o[%0d]", i), 32'(ram_dat_o[i]), 32'd0);
         check($sformatf("reset_rdata[%0d]", i), 32'(rdata[i]), 32'd0);
      end
      for (int i = 0; i < N; i++) rst[i] = 1'b0;

      // Port 0 write then read, W=2; the write-to-read turnaround rides along.
      access(0, 0, 1'b1, 18'h00010, 16'hA55A, 2'b11, r);
      check("wr_gnt_cycle", r.gnt_at, 1);
      check("wr_we_width", r.we_low, 2);
      check("wr_cs_width", r.cs_low, 2);
      check("wr_doe_turn", 32'(r.doe_turn), 32'd1);
      check("wr_doe_idle", 32'(r.doe_idle), 32'd0);
      access(0, 0, 1'b0, 18'h00010, 16'h0000, 2'b11, r);
      check("rd_rvalid_cycle", r.rv_at, 3);
      check("rd_data", 32'(r.rd), 32'h0000A55A);
      check("rd_we_width", r.we_low, 0);

      // Byte lanes: low-byte write from port 1, then full and high-only reads.
      access(0, 1, 1'b1, 18'h00020, 16'h1234, 2'b01, r);
      check("lane_lb_cycles", r.lb_low, 2);
      check("lane_ub_cycles", r.ub_low, 0);
      access(0, 0, 0, 18'h00020, 16'h0000, 2'b11, r);
      check("lane_rd_full", 32'(r.rd), 32'h0000E334);
      access(0, 1, 0, 18'h00020, 16'h0000, 2'b10, r);
      check("lane_rd_high", 32'(r.rd), 32'h0000E300);
      check("lane_rd_rvalid", r.rv_at, 3);

      // Reset in the 2nd ACCESS cycle of a write, then contention from release.
      drive(0, 1, 1'b1, 1'b1, 18'h00040, 16'hBEEF, 2'b11);
      @(negedge clk);
      check("abort_gnt1", 32'(gnt1[0]), 32'd1);
      drop(0, 1);
      @(posedge clk);
      #1;
      check("abort_pre_rst", 32'({ram_we[0], ram_dat_oe[0]}), 32'b01);
      rst[0] = 1'b1;
      #1;
      check("abort_async_pins", 32'(pins(0)), 32'(PINS_IDLE));
      check("abort_async_adr", 32'(ram_adr[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      contend(0, 6, 4);

      // Parameter sweep: W=1 and W=15.
      contend(1, 4, 3);
      contend(2, 4, 17);
      for (int i = 1; i < N; i++) begin
         access(i, 0, 1'b1, 18'h00050, 16'h0F0F, 2'b11, r);
         check($sformatf("sweep_cs_width[%0d]", i), r.cs_low, w_of(i));
         check($sformatf("sweep_we_width[%0d]", i), r.we_low, w_of(i));
         access(i, 1, 1'b0, 18'h00050, 16'h0000, 2'b00, r);
         check($sformatf("sweep_be00_rvalid[%0d]", i), r.rv_at, w_of(i) + 1);
         check($sformatf("sweep_be00_data[%0d]", i), 32'(r.rd), 32'h0);
         check($sformatf("sweep_be00_lanes[%0d]", i), r.lb_low + r.ub_low, 0);
         access(i, 0, 1'b0, 18'h00050, 16'h0000, 2'b11, r);
         check($sformatf("sweep_rd_data[%0d]", i), 32'(r.rd), 32'h00000F0F);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
